// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// A load hit returns data combinationally, and a store hit merges bytes at the clock edge.
// A miss stalls the pipeline while the FSM first writes back a dirty victim,
// then refills the line one word at a time over the memory port.
module dcache_dm_wb #(
  parameter int SET_LOG  = 4,
  parameter int WORD_LOG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int SETS  = 1 << SET_LOG;
  localparam int WORDS = 1 << WORD_LOG;
  localparam int TAG_W = 32 - SET_LOG - WORD_LOG - 2;
  localparam logic [WORD_LOG-1:0] CNT_ONE  = WORD_LOG'(1);
  localparam logic [WORD_LOG-1:0] CNT_LAST = WORD_LOG'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t              state;
  logic [WORD_LOG-1:0] cnt;

  logic [SETS-1:0]  valid;
  logic [SETS-1:0]  dirty;
  logic [TAG_W-1:0] tag_ram  [SETS];
  logic [31:0]      line_ram [SETS*WORDS];

  logic [WORD_LOG-1:0] offset;
  logic [SET_LOG-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic                req;
  logic                hit;
  logic                load_hit;
  logic                store_hit;
  logic                last_ack;
  logic                unused_addr_bits;

  // Merge the byte lanes selected by be from nw into old.
  function automatic logic [31:0] merge_be(input logic [31:0] old,
                                           input logic [31:0] nw,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = nw[8*b +: 8];
    end
    return res;
  endfunction

  assign offset = addr[WORD_LOG+1:2];
  assign index  = addr[WORD_LOG+2+SET_LOG-1:WORD_LOG+2];
  assign tag    = addr[31:32-TAG_W];
  assign unused_addr_bits = ^addr[1:0];

  // A simultaneous rd_req and wr_req is treated as a store.
  assign req       = rd_req | wr_req;
  assign hit       = valid[index] && (tag_ram[index] == tag);
  assign load_hit  = rd_req && !wr_req && hit && (state == IDLE);
  assign store_hit = wr_req && hit && (state == IDLE) && !rst;
  assign last_ack  = mem_ack && (cnt == CNT_LAST);

  assign miss    = !rst && req && (!hit || (state != IDLE));
  assign rd_data = load_hit ? line_ram[{index, offset}] : 32'd0;

  // Memory port outputs are pure decodes of the registered state and counter.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state)
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_ram[index], index, cnt, 2'b00};
        mem_wdata = line_ram[{index, cnt}];
      end
      FILL: begin
        mem_req   = 1'b1;
        mem_addr  = {tag, index, cnt, 2'b00};
      end
      default: ;
    endcase
  end

  // Miss FSM: the state, the word counter and the valid/dirty bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            cnt   <= '0;
            state <= (valid[index] && dirty[index]) ? WB : FILL;
          end else if (store_hit) begin
            dirty[index] <= 1'b1;
          end
        end
        WB: begin
          if (last_ack) begin
            cnt          <= '0;
            dirty[index] <= 1'b0;
            state        <= FILL;
          end else if (mem_ack) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        FILL: begin
          if (last_ack) begin
            cnt          <= '0;
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
            state        <= IDLE;
          end else if (mem_ack) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The tag is written only when the last refill word lands, so an aborted fill never looks valid.
  always_ff @(posedge clk) begin
    if (!rst && (state == FILL) && last_ack) begin
      tag_ram[index] <= tag;
    end
  end

  // Line storage is written by refill words or by a committing store hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((state == FILL) && mem_ack) begin
        line_ram[{index, cnt}] <= mem_rdata;
      end else if (store_hit) begin
        line_ram[{index, offset}] <= merge_be(line_ram[{index, offset}], wr_data, wr_be);
      end
    end
  end

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Directed bench for dcache_dm_wb.
// A word-serial memory model with configurable wait states answers the cache.
// Every memory transfer is logged and compared against hand-computed sequences.
module tb_dcache_dm_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  dcache_dm_wb #(.SET_LOG(4), .WORD_LOG(2)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data), .miss(miss),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];
  bit          log_we    [$];
  logic [31:0] log_addr  [$];
  logic [31:0] log_wdata [$];

  int          wc;
  int          waits_cfg;
  logic        hold_prev;
  logic [31:0] prev_addr;
  logic        s_miss;
  logic        s_mem_req;
  logic [31:0] s_rd_data;
  int          mc;
  logic [31:0] rdv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_wdata.delete();
  endtask

  task automatic check_entry(input string tag, input int k, input bit we,
                             input logic [31:0] a, input logic [31:0] wd);
    check({tag, "_present"}, 32'(k < log_addr.size()), 32'd1);
    if (k < log_addr.size()) begin
      check({tag, "_we"}, 32'(log_we[k]), 32'(we));
      check({tag, "_addr"}, log_addr[k], a);
      if (we) check({tag, "_wdata"}, log_wdata[k], wd);
    end
  endtask

  // One clock cycle, entered and left at the falling edge: answer memory, sample, log.
  task automatic tick();
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    if (mem_req && (wc >= waits_cfg)) begin
      mem_ack = 1'b1;
      if (!mem_we) mem_rdata = mem[mem_addr[11:2]];
    end
    #1;
    s_miss    = miss;
    s_mem_req = mem_req;
    s_rd_data = rd_data;
    if (hold_prev && mem_req) check("addr_hold", mem_addr, prev_addr);
    hold_prev = mem_req && !mem_ack;
    prev_addr = mem_addr;
    if (mem_req && mem_ack) begin
      log_we.push_back(mem_we);
      log_addr.push_back(mem_addr);
      log_wdata.push_back(mem_wdata);
      if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
      wc = 0;
    end else if (mem_req) begin
      wc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request and hold it until miss drops; returns miss cycle count and hit data.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input int waits,
                         output int mcyc, output logic [31:0] rval);
    bit done;
    done      = 1'b0;
    rd_req    = rd;
    wr_req    = wr;
    addr      = a;
    wr_data   = wd;
    wr_be     = be;
    waits_cfg = waits;
    wc        = 0;
    mcyc      = 0;
    rval      = 32'd0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!s_miss) begin
        done = 1'b1;
        rval = s_rd_data;
        break;
      end
      mcyc++;
    end
    check("req_done", 32'(done), 32'd1);
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    rd_req    = 1'b1;
    wr_req    = 1'b0;
    addr      = 32'h40;
    wr_data   = 32'd0;
    wr_be     = 4'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    wc        = 0;
    waits_cfg = 0;
    hold_prev = 1'b0;
    prev_addr = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[32'h40 >> 2]  = 32'h11;  mem[32'h44 >> 2]  = 32'h22;
    mem[32'h48 >> 2]  = 32'h33;  mem[32'h4C >> 2]  = 32'h44;
    mem[32'h440 >> 2] = 32'h55;  mem[32'h444 >> 2] = 32'h66;
    mem[32'h448 >> 2] = 32'h77;  mem[32'h44C >> 2] = 32'h88;
    mem[32'h800 >> 2] = 32'hA0;  mem[32'h804 >> 2] = 32'hA1;
    mem[32'h808 >> 2] = 32'hA2;  mem[32'h80C >> 2] = 32'hA3;
    mem[32'hC40 >> 2] = 32'hB0;  mem[32'hC44 >> 2] = 32'hB1;
    mem[32'hC48 >> 2] = 32'hB2;  mem[32'hC4C >> 2] = 32'hB3;

    // Reset with a load pending: no stall and no memory traffic.
    @(negedge clk);
    tick();
    check("rst_miss", 32'(s_miss), 32'd0);
    check("rst_mem_req", 32'(s_mem_req), 32'd0);
    check("rst_rd_data", s_rd_data, 32'd0);
    rst    = 1'b0;
    rd_req = 1'b0;
    tick();
    clear_log();

    // Cold load miss: clean fill of line 4.
    run_req(1'b1, 1'b0, 32'h40, 32'd0, 4'd0, 0, mc, rdv);
    check("cold_miss_cycles", 32'(mc), 32'd5);
    check("cold_rd_data", rdv, 32'h11);
    check("cold_log_n", 32'(log_addr.size()), 32'd4);
    for (int k = 0; k < 4; k++) check_entry("cold_fill", k, 1'b0, 32'h40 + 32'(4 * k), 32'd0);

    // Load hit in the same line.
    clear_log();
    run_req(1'b1, 1'b0, 32'h48, 32'd0, 4'd0, 0, mc, rdv);
    check("hit_miss_cycles", 32'(mc), 32'd0);
    check("hit_rd_data", rdv, 32'h33);

    // Partial store hit, then read back the merged word.
    run_req(1'b0, 1'b1, 32'h44, 32'hAABBCCDD, 4'b0011, 0, mc, rdv);
    check("st_hit_miss_cycles", 32'(mc), 32'd0);
    run_req(1'b1, 1'b0, 32'h44, 32'd0, 4'd0, 0, mc, rdv);
    check("st_merge_rd_data", rdv, 32'h0000CCDD);
    check("hit_no_traffic", 32'(log_addr.size()), 32'd0);

    // Conflict miss on the dirty line: write-back then fill.
    clear_log();
    run_req(1'b1, 1'b0, 32'h440, 32'd0, 4'd0, 0, mc, rdv);
    check("dirty_miss_cycles", 32'(mc), 32'd9);
    check("dirty_rd_data", rdv, 32'h55);
    check("dirty_log_n", 32'(log_addr.size()), 32'd8);
    check_entry("wb0", 0, 1'b1, 32'h40, 32'h11);
    check_entry("wb1", 1, 1'b1, 32'h44, 32'h0000CCDD);
    check_entry("wb2", 2, 1'b1, 32'h48, 32'h33);
    check_entry("wb3", 3, 1'b1, 32'h4C, 32'h44);
    for (int k = 0; k < 4; k++) check_entry("dirty_fill", 4 + k, 1'b0, 32'h440 + 32'(4 * k), 32'd0);
    check("wb_mem_word", mem[32'h44 >> 2], 32'h0000CCDD);

    // Store miss with three wait states per word, then read it back.
    clear_log();
    run_req(1'b0, 1'b1, 32'h804, 32'hDEADBEEF, 4'b1111, 3, mc, rdv);
    check("slow_miss_cycles", 32'(mc), 32'd17);
    check("slow_log_n", 32'(log_addr.size()), 32'd4);
    for (int k = 0; k < 4; k++) check_entry("slow_fill", k, 1'b0, 32'h800 + 32'(4 * k), 32'd0);
    run_req(1'b1, 1'b0, 32'h804, 32'd0, 4'd0, 0, mc, rdv);
    check("alloc_miss_cycles", 32'(mc), 32'd0);
    check("alloc_rd_data", rdv, 32'hDEADBEEF);
    run_req(1'b1, 1'b0, 32'h800, 32'd0, 4'd0, 0, mc, rdv);
    check("alloc_neighbor", rdv, 32'hA0);

    // Reset during the second fill word aborts the transfer.
    clear_log();
    rd_req    = 1'b1;
    addr      = 32'hC40;
    waits_cfg = 0;
    wc        = 0;
    tick();
    check("abort_start_miss", 32'(s_miss), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    rd_req = 1'b0;
    tick();
    check("abort_mem_req", 32'(s_mem_req), 32'd0);
    check("abort_miss", 32'(s_miss), 32'd0);
    check("abort_log_n", 32'(log_addr.size()), 32'd2);

    clear_log();
    run_req(1'b1, 1'b0, 32'hC40, 32'd0, 4'd0, 0, mc, rdv);
    check("refill_miss_cycles", 32'(mc), 32'd5);
    check("refill_rd_data", rdv, 32'hB0);
    check("refill_log_n", 32'(log_addr.size()), 32'd4);
    for (int k = 0; k < 4; k++) check_entry("refill", k, 1'b0, 32'hC40 + 32'(4 * k), 32'd0);

    // Reset also dropped the dirty store line: clean refill, old memory data.
    clear_log();
    run_req(1'b1, 1'b0, 32'h804, 32'd0, 4'd0, 0, mc, rdv);
    check("post_rst_miss_cycles", 32'(mc), 32'd5);
    check("post_rst_rd_data", rdv, 32'hA1);
    check("post_rst_log_n", 32'(log_addr.size()), 32'd4);

    // No request on a missing address: no stall, no traffic.
    rd_req = 1'b0;
    wr_req = 1'b0;
    addr   = 32'hF00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_miss", 32'(s_miss), 32'd0);
      check("idle_mem_req", 32'(s_mem_req), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
